// File: rtl/ip_rx_udp_filter.sv
// ---------------------------------------------------------------------------
// ip_rx_udp_filter
//
// Sits between an IPv4 receive parser and the UDP receive adapter. Each
// incoming IP header is latched and tested: UDP packets addressed to this
// host are forwarded to the adapter together with their payload. Everything
// else is swallowed. The address test accepts the local unicast address, the
// limited broadcast, the subnet directed broadcast and any multicast group.
//
// Ports
//   clk, rst_n           single clock, synchronous active-low reset
//   enable               1 = accept new headers; an open packet always finishes
//   local_ip             local IPv4 address (first octet in bits [31:24])
//   subnet_mask          subnet mask, same byte order as local_ip
//   s_ip_hdr_*           upstream header handshake and header fields
//   s_ip_payload_*       upstream payload AXI-Stream (8-bit)
//   m_ip_hdr_*           downstream header handshake and registered fields
//   m_ip_payload_*       downstream payload AXI-Stream (8-bit)
//   pass_count           packets forwarded, saturating at 0xFFFF
//   drop_count           packets rejected, saturating at 0xFFFF
// ---------------------------------------------------------------------------
module ip_rx_udp_filter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] local_ip,
  input  logic [31:0] subnet_mask,

  input  logic        s_ip_hdr_valid,
  output logic        s_ip_hdr_ready,
  input  logic [15:0] s_ip_length,
  input  logic [7:0]  s_ip_protocol,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,

  input  logic [7:0]  s_ip_payload_tdata,
  input  logic        s_ip_payload_tvalid,
  output logic        s_ip_payload_tready,
  input  logic        s_ip_payload_tlast,

  output logic        m_ip_hdr_valid,
  input  logic        m_ip_hdr_ready,
  output logic [15:0] m_ip_length,
  output logic [7:0]  m_ip_protocol,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,

  output logic [7:0]  m_ip_payload_tdata,
  output logic        m_ip_payload_tvalid,
  input  logic        m_ip_payload_tready,
  output logic        m_ip_payload_tlast,

  output logic [15:0] pass_count,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR_OUT,
    ST_PASS,
    ST_DROP
  } state_t;

  localparam logic [7:0]  PROTO_UDP = 8'd17;
  localparam logic [31:0] BCAST_ALL = 32'hFFFF_FFFF;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t      r_state;
  logic [15:0] r_length;
  logic [7:0]  r_protocol;
  logic [31:0] r_source_ip;
  logic [31:0] r_dest_ip;
  logic [15:0] r_pass_count;
  logic [15:0] r_drop_count;

  logic w_in_idle;
  logic w_in_pass;
  logic w_in_drop;
  logic w_hdr_fire;
  logic w_dest_match;
  logic w_accept;
  logic w_pass_last;
  logic w_drop_last;

  // NOTE: every combinational signal here is a continuous assign with a value
  // on every path, so no storage (latch) can be inferred for them.
  assign w_in_idle = (r_state == ST_IDLE);
  assign w_in_pass = (r_state == ST_PASS);
  assign w_in_drop = (r_state == ST_DROP);

  // rst_n gates the ready so no header can be taken while reset is asserted.
  assign s_ip_hdr_ready = rst_n & enable & w_in_idle;
  assign w_hdr_fire     = s_ip_hdr_valid & s_ip_hdr_ready;

  // Decision is made on the incoming fields, not on the registered copy, so
  // the header can be presented downstream on the very next cycle.
  assign w_dest_match = (s_ip_dest_ip == local_ip)
                      | (s_ip_dest_ip == BCAST_ALL)
                      | (s_ip_dest_ip == (local_ip | ~subnet_mask))
                      | (s_ip_dest_ip[31:28] == 4'hE);
  assign w_accept     = (s_ip_protocol == PROTO_UDP) & w_dest_match;

  assign w_pass_last = w_in_pass & s_ip_payload_tvalid & m_ip_payload_tready
                     & s_ip_payload_tlast;
  assign w_drop_last = w_in_drop & s_ip_payload_tvalid & s_ip_payload_tlast;

  // Payload is a pure passthrough in PASS and forced quiet elsewhere, so a beat
  // that shows up before its header is held off upstream.
  assign m_ip_payload_tvalid = w_in_pass & s_ip_payload_tvalid;
  assign m_ip_payload_tdata  = w_in_pass ? s_ip_payload_tdata : 8'h00;
  assign m_ip_payload_tlast  = w_in_pass & s_ip_payload_tlast;
  assign s_ip_payload_tready = (w_in_pass & m_ip_payload_tready) | w_in_drop;

  assign m_ip_hdr_valid = (r_state == ST_HDR_OUT);
  assign m_ip_length    = r_length;
  assign m_ip_protocol  = r_protocol;
  assign m_ip_source_ip = r_source_ip;
  assign m_ip_dest_ip   = r_dest_ip;
  assign pass_count     = r_pass_count;
  assign drop_count     = r_drop_count;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the header registers are plain flops, not a memory, so clearing
      // them in reset is cheap and leaves the downstream fields defined.
      r_state      <= ST_IDLE;
      r_length     <= '0;
      r_protocol   <= '0;
      r_source_ip  <= '0;
      r_dest_ip    <= '0;
      r_pass_count <= '0;
      r_drop_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hdr_fire) begin
            r_length    <= s_ip_length;
            r_protocol  <= s_ip_protocol;
            r_source_ip <= s_ip_source_ip;
            r_dest_ip   <= s_ip_dest_ip;
            if (w_accept) begin
              r_state <= ST_HDR_OUT;
            end else begin
              r_state <= ST_DROP;
              if (r_drop_count != CNT_MAX) begin
                r_drop_count <= r_drop_count + 16'd1;
              end
            end
          end
        end
        ST_HDR_OUT: begin
          if (m_ip_hdr_ready) begin
            r_state <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (w_pass_last) begin
            r_state <= ST_IDLE;
            if (r_pass_count != CNT_MAX) begin
              r_pass_count <= r_pass_count + 16'd1;
            end
          end
        end
        ST_DROP: begin
          if (w_drop_last) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
